// File: rtl/digital_lock.sv
// digital_lock: 4-bit code lock with a limited number of attempts, built from a datapath and a Moore controller.
module digital_lock_dp #(
  parameter logic [3:0] PASSWORD     = 4'b0111,
  parameter int         MAX_ATTEMPTS = 3,
  parameter int         CNT_W        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] data_in,
  input  logic       ldep,
  input  logic       clep,
  input  logic       incc,
  output logic       equal,
  output logic       not_equal,
  output logic       lte,
  output logic       gt
);
  logic [3:0]       ua_q, ua_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    ua_d      = clep ? '0 : ldep ? data_in : ua_q;
    cnt_d     = clep ? '0 : (incc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    equal     = (ua_q == PASSWORD);
    not_equal = ~equal;
    lte       = (cnt_q <= CNT_W'(MAX_ATTEMPTS - 1));
    gt        = ~lte;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ua_q  <= '0;
      cnt_q <= '0;
    end else begin
      ua_q  <= ua_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

module digital_lock_ctrl (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic equal,
  input  logic not_equal,
  input  logic lte,
  input  logic gt,
  output logic ldep,
  output logic clep,
  output logic incc,
  output logic done,
  output logic unlock,
  output logic alarm
);
  typedef enum logic [2:0] {IDLE, LOAD, CHECK, UNLOCK, ALARM} state_t;
  state_t state_q, state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = CHECK;
      // equal wins so a match on the last allowed attempt still unlocks
      CHECK:   state_d = equal ? UNLOCK : (not_equal && lte) ? LOAD : (not_equal && gt) ? ALARM : CHECK;
      UNLOCK:  if (!start) state_d = IDLE;
      ALARM:   state_d = ALARM;
      default: state_d = IDLE;
    endcase
    clep   = (state_q == IDLE);
    ldep   = (state_q == LOAD);
    incc   = (state_q == LOAD);
    unlock = (state_q == UNLOCK);
    alarm  = (state_q == ALARM);
    done   = unlock | alarm;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
endmodule

module digital_lock #(
  parameter logic [3:0] PASSWORD     = 4'b0111,
  parameter int         MAX_ATTEMPTS = 3,
  parameter int         CNT_W        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] data_in,
  output logic       done,
  output logic       unlock,
  output logic       alarm
);
  logic ldep, clep, incc, equal, not_equal, lte, gt;
  digital_lock_dp #(
    .PASSWORD(PASSWORD), .MAX_ATTEMPTS(MAX_ATTEMPTS), .CNT_W(CNT_W)
  ) u_dp (
    .clk(clk), .rst(rst), .data_in(data_in),
    .ldep(ldep), .clep(clep), .incc(incc),
    .equal(equal), .not_equal(not_equal), .lte(lte), .gt(gt)
  );
  digital_lock_ctrl u_ctrl (
    .clk(clk), .rst(rst), .start(start),
    .equal(equal), .not_equal(not_equal), .lte(lte), .gt(gt),
    .ldep(ldep), .clep(clep), .incc(incc),
    .done(done), .unlock(unlock), .alarm(alarm)
  );
endmodule

// File: tb/tb_digital_lock.sv
// tb_digital_lock: session-level model of the lock checked every cycle, plus directed literal checks.
module tb_digital_lock;
  localparam logic [3:0] PW  = 4'd7;
  localparam int         MAX = 3;
  localparam int M_IDLE = 0, M_RUN = 1, M_OPEN = 2, M_ALARM = 3;

  logic       clk = 0;
  logic       rst = 1;
  logic       start = 0;
  logic [3:0] data_in = 0;
  logic       done, unlock, alarm;

  int checks = 0;
  int failures = 0;

  int         m_mode = M_IDLE;
  int         m_t = 0;
  int         m_n = 0;
  logic [3:0] m_ua = 0;

  digital_lock dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .done(done), .unlock(unlock), .alarm(alarm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // A session: start seen in idle, then entries sampled every odd edge, verdict every even edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = M_IDLE; m_t = 0; m_n = 0; m_ua = 0;
    end else if (m_mode == M_IDLE) begin
      m_n = 0; m_ua = 0;
      if (start === 1'b1) begin m_mode = M_RUN; m_t = 0; end
    end else if (m_mode == M_RUN) begin
      m_t++;
      if (m_t % 2 == 1) begin
        m_ua = data_in;
        m_n = (m_n < 15) ? m_n + 1 : m_n;
      end else if (m_ua == PW) m_mode = M_OPEN;
      else if (m_n >= MAX) m_mode = M_ALARM;
    end else if (m_mode == M_OPEN) begin
      if (start !== 1'b1) m_mode = M_IDLE;
    end
  end

  always @(negedge clk) begin
    chk("cyc_unlock", {7'd0, unlock}, {7'd0, m_mode == M_OPEN});
    chk("cyc_alarm",  {7'd0, alarm},  {7'd0, m_mode == M_ALARM});
    chk("cyc_done",   {7'd0, done},   {7'd0, m_mode == M_OPEN || m_mode == M_ALARM});
    chk("cyc_excl",   {7'd0, unlock & alarm}, 8'd0);
    chk("cyc_ua",     {4'd0, dut.u_dp.ua_q}, {4'd0, m_ua});
    chk("cyc_cnt",    {4'd0, dut.u_dp.cnt_q}, 8'(m_n));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic entries(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    start = 1; step(1);
    data_in = a; step(1);
    chk("att1_pending", {7'd0, done}, 8'd0);
    data_in = b; step(2);
    data_in = c; step(2);
    chk("att3_pending", {7'd0, done}, 8'd0);
    step(1);
  endtask

  initial begin
    step(2);
    chk("rst_done", {7'd0, done}, 8'd0);
    chk("rst_cnt", {4'd0, dut.u_dp.cnt_q}, 8'd0);
    // T1: correct code on first attempt
    rst = 0; start = 1; data_in = 7;
    step(2);
    chk("t1_ua_loaded", {4'd0, dut.u_dp.ua_q}, 8'd7);
    chk("t1_not_yet", {7'd0, unlock}, 8'd0);
    step(1);
    chk("t1_unlock", {7'd0, unlock}, 8'd1);
    chk("t1_done", {7'd0, done}, 8'd1);
    chk("t1_alarm", {7'd0, alarm}, 8'd0);
    step(3);
    chk("t1_hold", {7'd0, unlock}, 8'd1);
    // T4: release, then a wrong restart
    start = 0; data_in = 9;
    step(1);
    chk("t4_idle_unlock", {7'd0, unlock}, 8'd0);
    chk("t4_idle_done", {7'd0, done}, 8'd0);
    step(1);
    chk("t4_ua_clr", {4'd0, dut.u_dp.ua_q}, 8'd0);
    chk("t4_cnt_clr", {4'd0, dut.u_dp.cnt_q}, 8'd0);
    start = 1;
    step(3);
    chk("t4_wrong", {7'd0, unlock}, 8'd0);
    rst = 1; step(1); rst = 0; start = 0; step(1);
    // T2: three wrong entries
    entries(9, 6, 5);
    chk("t2_alarm", {7'd0, alarm}, 8'd1);
    chk("t2_done", {7'd0, done}, 8'd1);
    chk("t2_unlock", {7'd0, unlock}, 8'd0);
    chk("t2_cnt", {4'd0, dut.u_dp.cnt_q}, 8'd3);
    // T5: alarm is sticky
    for (int i = 0; i < 6; i++) begin
      start = i[0]; data_in = 7; step(1);
    end
    chk("t5_sticky", {7'd0, alarm}, 8'd1);
    chk("t5_no_unlock", {7'd0, unlock}, 8'd0);
    rst = 1; step(1); rst = 0; start = 0; step(1);
    chk("t5_cleared", {7'd0, alarm}, 8'd0);
    // T3: match on last allowed attempt; start dropped mid-session
    start = 1; step(1);
    data_in = 9; start = 0; step(1);
    data_in = 6; start = 1; step(2);
    data_in = 7; step(3);
    chk("t3_unlock", {7'd0, unlock}, 8'd1);
    chk("t3_alarm", {7'd0, alarm}, 8'd0);
    chk("t3_cnt", {4'd0, dut.u_dp.cnt_q}, 8'd3);
    // T6: asynchronous reset while in CHECK
    rst = 1; step(1); rst = 0; start = 1; data_in = 9;
    step(2);
    chk("t6_pre_cnt", {4'd0, dut.u_dp.cnt_q}, 8'd1);
    #1 rst = 1;
    #1;
    chk("t6_cnt", {4'd0, dut.u_dp.cnt_q}, 8'd0);
    chk("t6_ua", {4'd0, dut.u_dp.ua_q}, 8'd0);
    chk("t6_done", {7'd0, done}, 8'd0);
    step(1); rst = 0; data_in = 7;
    step(3);
    chk("t6_unlock", {7'd0, unlock}, 8'd1);
    #1 rst = 1;
    #1;
    chk("t6_async_unlock", {7'd0, unlock}, 8'd0);
    chk("t6_async_done", {7'd0, done}, 8'd0);
    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
